// File: rtl/dbus_arb_pkg.sv
// Shared types and constants for the two-master D-bus arbiter.
package dbus_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    localparam logic M_CORE = 1'b0;
    localparam logic M_DBG  = 1'b1;

    localparam logic TT_READ  = 1'b0;
    localparam logic TT_WRITE = 1'b1;

    localparam logic [1:0] TS_BYTE     = 2'd0;
    localparam logic [1:0] TS_HALFWORD = 2'd1;
    localparam logic [1:0] TS_WORD     = 2'd2;

endpackage

// File: rtl/dbus_arbiter_rr_pick2.sv
// Two-way round-robin winner: a tie goes to the master that was not granted last.
module dbus_arbiter_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt,
    output logic       any
);
    always_comb begin
        any = |req;
        gnt = (req == 2'b11) ? ~last_grant : req[1];
    end
endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates core0 data port (m0) and debug SBA (m1) onto the single D-bus
// slave path, one outstanding transaction, with timeout-forced completion.
module dbus_arbiter
    import dbus_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_ttype,
    input  logic [1:0]    m0_tsize,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_done,
    output logic          m0_err,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_ttype,
    input  logic [1:0]    m1_tsize,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_done,
    output logic          m1_err,
    output logic          s_bstart,
    output logic [AW-1:0] s_addr,
    output logic          s_ttype,
    output logic [1:0]    s_tsize,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_done,
    output logic          s_abort,
    output logic          owner
);
    arb_state_t    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic          s_bstart_q, s_bstart_d;
    logic          s_abort_q, s_abort_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic          s_ttype_q, s_ttype_d;
    logic [1:0]    s_tsize_q, s_tsize_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic          m0_done_q, m0_done_d, m1_done_q, m1_done_d;
    logic          m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic          gnt, any;
    logic          fin;
    logic          fin_err;
    logic [DW-1:0] fin_rdata;

    dbus_arbiter_rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .any        (any)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        s_bstart_d   = 1'b0;
        s_abort_d    = 1'b0;
        s_addr_d     = s_addr_q;
        s_ttype_d    = s_ttype_q;
        s_tsize_d    = s_tsize_q;
        s_wdata_d    = s_wdata_q;
        fin          = 1'b0;
        fin_err      = 1'b0;
        fin_rdata    = '0;

        case (state_q)
            IDLE: begin
                if (any) begin
                    owner_d    = gnt;
                    s_addr_d   = gnt ? m1_addr  : m0_addr;
                    s_ttype_d  = gnt ? m1_ttype : m0_ttype;
                    s_tsize_d  = gnt ? m1_tsize : m0_tsize;
                    s_wdata_d  = gnt ? m1_wdata : m0_wdata;
                    s_bstart_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                // A completion arriving on the timeout cycle still counts as normal.
                if (s_done) begin
                    fin       = 1'b1;
                    fin_rdata = (s_ttype_q == TT_WRITE) ? '0 : s_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                    s_abort_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (fin) begin
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        m0_done_d  = fin && (owner_q == M_CORE);
        m1_done_d  = fin && (owner_q == M_DBG);
        m0_err_d   = m0_done_d && fin_err;
        m1_err_d   = m1_done_d && fin_err;
        m0_rdata_d = m0_done_d ? fin_rdata : m0_rdata_q;
        m1_rdata_d = m1_done_d ? fin_rdata : m1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= M_DBG;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            s_bstart_q   <= 1'b0;
            s_abort_q    <= 1'b0;
            s_addr_q     <= '0;
            s_ttype_q    <= 1'b0;
            s_tsize_q    <= 2'd0;
            s_wdata_q    <= '0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            s_bstart_q   <= s_bstart_d;
            s_abort_q    <= s_abort_d;
            s_addr_q     <= s_addr_d;
            s_ttype_q    <= s_ttype_d;
            s_tsize_q    <= s_tsize_d;
            s_wdata_q    <= s_wdata_d;
            m0_done_q    <= m0_done_d;
            m1_done_q    <= m1_done_d;
            m0_err_q     <= m0_err_d;
            m1_err_q     <= m1_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(m0_done_q && m1_done_q));
            assert (!(state_q == WAIT && s_bstart_d));
        end
    end

    assign s_bstart = s_bstart_q;
    assign s_abort  = s_abort_q;
    assign s_addr   = s_addr_q;
    assign s_ttype  = s_ttype_q;
    assign s_tsize  = s_tsize_q;
    assign s_wdata  = s_wdata_q;
    assign owner    = owner_q;
    assign m0_done  = m0_done_q;
    assign m1_done  = m1_done_q;
    assign m0_err   = m0_err_q;
    assign m1_err   = m1_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: reset, single master, tie-break, contention,
// timeout, timeout race and reset mid-transaction.
module tb_dbus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m1_req;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_ttype, m1_ttype;
    logic [1:0]    m0_tsize, m1_tsize;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_done, m1_done, m0_err, m1_err;
    logic          s_bstart, s_ttype, s_done, s_abort, owner;
    logic [AW-1:0] s_addr;
    logic [1:0]    s_tsize;
    logic [DW-1:0] s_wdata, s_rdata;

    int checks = 0;
    int errors = 0;

    dbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
        .s_bstart(s_bstart), .s_addr(s_addr), .s_ttype(s_ttype), .s_tsize(s_tsize),
        .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done), .s_abort(s_abort),
        .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({s_bstart, s_abort, owner, m0_done, m1_done, m0_err, m1_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {s_bstart, s_abort, owner, m0_done, m1_done, m0_err, m1_err});
        end
        checks++;
        if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: s_addr=%h s_wdata=%h m0_rdata=%h m1_rdata=%h expected all 0",
                     s_addr, s_wdata, m0_rdata, m1_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_m0_only();
        m0_req = 1'b1; m0_addr = 32'h10; m0_ttype = 1'b0; m0_tsize = 2'd2;
        step();
        checks++;
        if (s_bstart !== 1'b1 || owner !== 1'b0 || s_addr !== 32'h10 || s_tsize !== 2'd2) begin
            errors++;
            $display("FAIL m0_start: bstart=%b owner=%b addr=%h tsize=%0d expected 1 0 00000010 2",
                     s_bstart, owner, s_addr, s_tsize);
        end
        step();
        checks++;
        if (s_bstart !== 1'b0 || s_addr !== 32'h10) begin
            errors++;
            $display("FAIL m0_bstart_pulse: bstart=%b addr=%h expected 0 00000010", s_bstart, s_addr);
        end
        step();
        s_done = 1'b1; s_rdata = 32'hCAFEBABE;
        step();
        s_done = 1'b0; m0_req = 1'b0;
        checks++;
        if (m0_done !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hCAFEBABE || m1_done !== 1'b0) begin
            errors++;
            $display("FAIL m0_done: done=%b err=%b rdata=%h m1_done=%b expected 1 0 cafebabe 0",
                     m0_done, m0_err, m0_rdata, m1_done);
        end
        step();
        checks++;
        if (m0_done !== 1'b0 || s_bstart !== 1'b0 || m0_rdata !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL m0_after: done=%b bstart=%b rdata=%h expected 0 0 cafebabe",
                     m0_done, s_bstart, m0_rdata);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1; step(); rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h20; m0_ttype = 1'b0; m0_tsize = 2'd2;
        m1_req = 1'b1; m1_addr = 32'h40; m1_ttype = 1'b1; m1_tsize = 2'd2; m1_wdata = 32'h1234;
        step();
        checks++;
        if (s_bstart !== 1'b1 || owner !== 1'b0 || s_addr !== 32'h20) begin
            errors++;
            $display("FAIL tie_first: bstart=%b owner=%b addr=%h expected 1 0 00000020",
                     s_bstart, owner, s_addr);
        end
        s_done = 1'b1; s_rdata = 32'h11111111;
        step();
        s_done = 1'b0; m0_req = 1'b0;
        checks++;
        if (m0_done !== 1'b1 || m0_rdata !== 32'h11111111 || m1_done !== 1'b0 || s_bstart !== 1'b0) begin
            errors++;
            $display("FAIL zero_wait: m0_done=%b rdata=%h m1_done=%b bstart=%b expected 1 11111111 0 0",
                     m0_done, m0_rdata, m1_done, s_bstart);
        end
        step();
        checks++;
        if (s_bstart !== 1'b1 || owner !== 1'b1 || s_addr !== 32'h40 || s_ttype !== 1'b1
            || s_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL m1_start: bstart=%b owner=%b addr=%h ttype=%b wdata=%h expected 1 1 00000040 1 00001234",
                     s_bstart, owner, s_addr, s_ttype, s_wdata);
        end
        step();
        s_done = 1'b1; s_rdata = 32'hDEADBEEF;
        step();
        s_done = 1'b0; m1_req = 1'b0;
        checks++;
        if (m1_done !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== 32'h0 || m0_done !== 1'b0
            || m0_rdata !== 32'h11111111) begin
            errors++;
            $display("FAIL m1_write_done: done=%b err=%b rdata=%h m0_done=%b m0_rdata=%h expected 1 0 00000000 0 11111111",
                     m1_done, m1_err, m1_rdata, m0_done, m0_rdata);
        end
        step();
    endtask

    task automatic test_contention();
        int wait_cnt;
        logic exp_own;
        rst = 1'b1; step(); rst = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h100; m0_ttype = 1'b0;
        m1_req = 1'b1; m1_addr = 32'h200; m1_ttype = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_own = i[0];
            wait_cnt = 0;
            while (s_bstart !== 1'b1 && wait_cnt < 3) begin
                step();
                wait_cnt++;
            end
            checks++;
            if (s_bstart !== 1'b1 || owner !== exp_own) begin
                errors++;
                $display("FAIL rr_grant%0d: bstart=%b owner=%b expected 1 %b", i, s_bstart, owner, exp_own);
            end
            step();
            s_done = 1'b1; s_rdata = 32'hA0 + i;
            step();
            s_done = 1'b0;
            checks++;
            if (m0_done !== !exp_own || m1_done !== exp_own
                || (exp_own ? m1_rdata : m0_rdata) !== 32'hA0 + i) begin
                errors++;
                $display("FAIL rr_done%0d: m0_done=%b m1_done=%b m0_rdata=%h m1_rdata=%h expected owner %b rdata %h",
                         i, m0_done, m1_done, m0_rdata, m1_rdata, exp_own, 32'hA0 + i);
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int early;
        m1_req = 1'b1; m1_addr = 32'h300; m1_ttype = 1'b0;
        step();
        checks++;
        if (s_bstart !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL to_start: bstart=%b owner=%b expected 1 1", s_bstart, owner);
        end
        early = 0;
        for (int k = 1; k < TO; k++) begin
            step();
            if (s_abort !== 1'b0 || m1_done !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL to_early: %0d early abort/done cycles, expected 0", early);
        end
        step();
        m1_req = 1'b0;
        checks++;
        if (s_abort !== 1'b1 || m1_done !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'h0
            || m0_done !== 1'b0) begin
            errors++;
            $display("FAIL to_abort: abort=%b done=%b err=%b rdata=%h m0_done=%b expected 1 1 1 00000000 0",
                     s_abort, m1_done, m1_err, m1_rdata, m0_done);
        end
        step();
        checks++;
        if (s_abort !== 1'b0 || m1_done !== 1'b0 || m1_err !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse: abort=%b done=%b err=%b expected 0 0 0", s_abort, m1_done, m1_err);
        end
        s_done = 1'b1; s_rdata = 32'h77777777;
        step();
        s_done = 1'b0;
        checks++;
        if (m0_done !== 1'b0 || m1_done !== 1'b0 || s_bstart !== 1'b0 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL late_done: m0_done=%b m1_done=%b bstart=%b m1_rdata=%h expected 0 0 0 00000000",
                     m0_done, m1_done, s_bstart, m1_rdata);
        end
    endtask

    task automatic test_race();
        m0_req = 1'b1; m0_addr = 32'h400; m0_ttype = 1'b0;
        step();
        for (int k = 1; k < TO; k++) step();
        s_done = 1'b1; s_rdata = 32'h5A5A5A5A;
        step();
        s_done = 1'b0; m0_req = 1'b0;
        checks++;
        if (m0_done !== 1'b1 || m0_err !== 1'b0 || s_abort !== 1'b0 || m0_rdata !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL race: done=%b err=%b abort=%b rdata=%h expected 1 0 0 5a5a5a5a",
                     m0_done, m0_err, s_abort, m0_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_addr = 32'h500; m1_ttype = 1'b0;
        step();
        checks++;
        if (s_bstart !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL rm_start: bstart=%b owner=%b expected 1 1", s_bstart, owner);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; m1_req = 1'b0;
        checks++;
        if ({s_bstart, s_abort, owner, m0_done, m1_done, m0_err, m1_err} !== 7'b0
            || s_addr !== '0 || m1_rdata !== '0 || m0_rdata !== '0) begin
            errors++;
            $display("FAIL rm_outputs: ctrl=%b addr=%h m0_rdata=%h m1_rdata=%h expected 0000000 0 0 0",
                     {s_bstart, s_abort, owner, m0_done, m1_done, m0_err, m1_err}, s_addr, m0_rdata, m1_rdata);
        end
        s_done = 1'b1; s_rdata = 32'h99;
        step();
        s_done = 1'b0;
        checks++;
        if (m0_done !== 1'b0 || m1_done !== 1'b0) begin
            errors++;
            $display("FAIL rm_no_done: m0_done=%b m1_done=%b expected 0 0", m0_done, m1_done);
        end
        m0_req = 1'b1; m0_addr = 32'h600;
        m1_req = 1'b1; m1_addr = 32'h700;
        step();
        checks++;
        if (s_bstart !== 1'b1 || owner !== 1'b0 || s_addr !== 32'h600) begin
            errors++;
            $display("FAIL rm_regrant: bstart=%b owner=%b addr=%h expected 1 0 00000600",
                     s_bstart, owner, s_addr);
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_ttype = 1'b0; m0_tsize = 2'd0; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_ttype = 1'b0; m1_tsize = 2'd0; m1_wdata = '0;
        s_done = 1'b0; s_rdata = '0;
        #1;
        test_reset();
        test_m0_only();
        test_simultaneous();
        test_contention();
        test_timeout();
        test_race();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
